// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM encoding, RGB565 byte packing and default DVP timing for the sensor emulator.
package cam_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_HBLANK, ST_VFRONT
    } cam_state_t;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_PCLK_HALF   = 2;
    function automatic logic [7:0] rgb565_byte(input logic [23:0] px, input logic lo);
        return lo ? {px[12:10], px[7:3]} : {px[23:19], px[15:13]};
    endfunction
endpackage

// File: rtl/cam_pclk_gen.sv
// cam_pclk_gen: pixel clock divider; rise/fall strobes are high in the sys_clk cycle whose edge toggles pclk.
module cam_pclk_gen #(
    parameter int PCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pclk,
    output logic rise_evt,
    output logic fall_evt
);
    localparam int CW = PCLK_HALF > 1 ? $clog2(PCLK_HALF) : 1;
    logic [CW-1:0] cnt;
    logic tick;
    assign tick = run && cnt == CW'(PCLK_HALF - 1);
    assign rise_evt = tick && !pclk;
    assign fall_evt = tick && pclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            pclk <= pclk ^ tick;
        end
    end
endmodule

// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP sensor emulator; streams RGB565 bytes with vsync/href/pclk framing, outputs moving on pclk falls.
module cam_dvp_tx import cam_pkg::*; #(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int PCLK_HALF   = DEF_PCLK_HALF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        enable_i,
    input  logic [23:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        pclk_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  cam_data_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic        underflow_o,
    output logic        busy_o
);
    localparam int LINE = 2 * H_ACTIVE + H_BLANK;
    localparam int VM1  = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
    localparam int VM2  = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
    localparam int VMAX = VM1 > VM2 ? VM1 : VM2;
    localparam int HW   = $clog2(LINE);
    localparam int VW   = VMAX > 1 ? $clog2(VMAX) : 1;

    cam_state_t state, ns;
    logic [HW-1:0] hcnt, nh;
    logic [VW-1:0] vcnt, nv;
    logic [23:0] px_q, src;
    logic run, fall_evt, unused_rise, h_end, fetch, start_evt;

    cam_pclk_gen #(.PCLK_HALF(PCLK_HALF)) u_pclk (
        .clk(sys_clk_i), .rst(sys_rst_i), .run(run),
        .pclk(pclk_o), .rise_evt(unused_rise), .fall_evt(fall_evt)
    );

    assign run = state != ST_IDLE;
    assign busy_o = run;
    assign h_end = hcnt == HW'(LINE - 1);

    always_comb begin
        ns = state;
        nh = h_end ? '0 : hcnt + 1'b1;
        nv = h_end ? vcnt + 1'b1 : vcnt;
        case (state)
            ST_START: begin
                ns = ST_VSYNC;
                nh = '0;
                nv = '0;
            end
            ST_VSYNC: if (h_end && vcnt == VW'(VSYNC_LINES - 1)) begin
                ns = ST_VBACK;
                nv = '0;
            end
            ST_VBACK: if (h_end && vcnt == VW'(V_BACK - 1)) begin
                ns = ST_ACTIVE;
                nv = '0;
            end
            ST_ACTIVE: ns = hcnt == HW'(2 * H_ACTIVE - 1) ? ST_HBLANK : ST_ACTIVE;
            ST_HBLANK: if (h_end) begin
                ns = vcnt == VW'(V_ACTIVE - 1) ? ST_VFRONT : ST_ACTIVE;
                nv = vcnt == VW'(V_ACTIVE - 1) ? '0 : vcnt + 1'b1;
            end
            ST_VFRONT: if (h_end && vcnt == VW'(V_FRONT - 1)) begin
                ns = enable_i ? ST_VSYNC : ST_IDLE;
                nv = '0;
            end
            default: begin
                ns = enable_i ? ST_START : ST_IDLE;
                nh = '0;
                nv = '0;
            end
        endcase
    end

    // Even byte index fetches a fresh pixel (zero on underflow); odd byte reuses the latch.
    assign fetch = fall_evt && ns == ST_ACTIVE && !nh[0];
    assign pix_ready_o = fetch;
    assign src = nh[0] ? px_q : (pix_valid_i ? pix_data_i : '0);
    assign start_evt = fall_evt && ns == ST_VSYNC && state != ST_VSYNC;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state         <= ST_IDLE;
            hcnt          <= '0;
            vcnt          <= '0;
            px_q          <= '0;
            vsync_o       <= 1'b0;
            href_o        <= 1'b0;
            cam_data_o    <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            frame_start_o <= start_evt;
            frame_done_o  <= fall_evt && state == ST_VFRONT && ns != ST_VFRONT;
            underflow_o   <= start_evt ? 1'b0 : underflow_o | (fetch & ~pix_valid_i);
            if (state == ST_IDLE) begin
                state <= ns;
            end else if (fall_evt) begin
                state      <= ns;
                hcnt       <= nh;
                vcnt       <= nv;
                vsync_o    <= ns == ST_VSYNC;
                href_o     <= ns == ST_ACTIVE;
                cam_data_o <= ns == ST_ACTIVE ? rgb565_byte(src, nh[0]) : '0;
                px_q       <= fetch ? src : px_q;
            end
        end
    end
endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb_cam_dvp_tx: scoreboard bench; the pixel driver queues expected bytes, the monitor checks bytes and framing.
module tb_cam_dvp_tx;
    typedef struct packed {
        logic        valid;
        logic [23:0] px;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } stim_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic pix_ready, pclk, vsync, href, frame_start, frame_done, underflow, busy;
    logic [7:0] cam_data;

    int checks = 0, failures = 0;
    stim_t stim_q[$];
    logic [7:0] exp_q[$];
    logic in_frame = 1'b0;

    logic [23:0] px_tab [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                                24'h123456, 24'hABCDEF, 24'h808080, 24'h000000};
    logic [7:0]  hi_tab [8] = '{8'hF8, 8'h07, 8'h00, 8'hFF, 8'h11, 8'hAE, 8'h84, 8'h00};
    logic [7:0]  lo_tab [8] = '{8'h00, 8'hE0, 8'h1F, 8'hFF, 8'hAA, 8'h7D, 8'h10, 8'h00};

    cam_dvp_tx #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .VSYNC_LINES(1),
                 .V_BACK(1), .V_FRONT(1), .PCLK_HALF(2)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .enable_i(enable),
        .pix_data_i(pix_data), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
        .pclk_o(pclk), .vsync_o(vsync), .href_o(href), .cam_data_o(cam_data),
        .frame_start_o(frame_start), .frame_done_o(frame_done),
        .underflow_o(underflow), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_frame(input int skip);
        for (int i = 0; i < 8; i++)
            stim_q.push_back('{valid: i != skip, px: px_tab[i], hi: hi_tab[i], lo: lo_tab[i]});
    endtask

    // which: 0 frame_start, 1 frame_done, 2 href high, 3 href low
    task automatic wait_for(input string name, input int which, input int budget);
        int n = 0;
        while (!(which == 0 ? frame_start : which == 1 ? frame_done : which == 2 ? href : !href)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < budget, 1);
    endtask

    // Pixel source: pushes the expected byte pair whenever the DUT consumes a pixel.
    initial begin
        stim_t e;
        forever begin
            @(negedge clk);
            if (pix_ready) begin
                if (stim_q.size() > 0) begin
                    e = stim_q.pop_front();
                    exp_q.push_back(e.valid ? e.hi : 8'h00);
                    exp_q.push_back(e.valid ? e.lo : 8'h00);
                end else begin
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'h00);
                end
                @(posedge clk);
                #1;
            end
            if (stim_q.size() > 0) begin
                pix_valid = stim_q[0].valid;
                pix_data = stim_q[0].px;
            end else begin
                pix_valid = 1'b0;
                pix_data = '0;
            end
        end
    end

    // Monitor: byte scoreboard, setup/hold stability around pclk rise, per-frame timing counts.
    initial begin
        logic pp = 1'b0, hp = 1'b0, post = 1'b0, rp = 1'b0, rstp = 1'b1, rise, seen_href = 1'b0;
        logic [9:0] cur, sp = '0, sr = '0;
        int n_rise = 0, n_vs = 0, n_pre = 0, n_href = 0, n_edge = 0, n_ready = 0;
        forever begin
            @(negedge clk);
            cur = {vsync, href, cam_data};
            rise = pclk && !pp;
            if (!rst && !rstp) begin
                if (rise) check("stable_before_rise", cur, sp);
                if (post) check("stable_after_rise", cur, sr);
                if (rp) check("ready_in_href", href, 1);
                if (rise && href) begin
                    if (exp_q.size() == 0) check("byte_unexpected", cam_data, 32'hFFFF_FFFF);
                    else check("byte", cam_data, exp_q.pop_front());
                end
            end
            if (in_frame) begin
                if (rise) begin
                    n_rise++;
                    if (vsync) n_vs++;
                    if (!vsync && !href && !seen_href) n_pre++;
                    if (href) begin
                        n_href++;
                        seen_href = 1'b1;
                    end
                end
                if (href && !hp) n_edge++;
                if (pix_ready) n_ready++;
                if (frame_done) begin
                    check("frame_pclks", n_rise, 50);
                    check("vsync_pclks", n_vs, 10);
                    check("vback_pclks", n_pre, 10);
                    check("href_pclks", n_href, 16);
                    check("href_lines", n_edge, 2);
                    check("ready_strobes", n_ready, 8);
                    in_frame = 1'b0;
                end
            end
            if (frame_start && !rst) begin
                in_frame = 1'b1;
                seen_href = 1'b0;
                n_rise = 0; n_vs = 0; n_pre = 0; n_href = 0; n_edge = 0; n_ready = 0;
            end
            post = rise;
            sr = cur;
            rp = pix_ready;
            pp = pclk;
            hp = href;
            sp = cur;
            rstp = rst;
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_outputs", {pix_ready, pclk, vsync, href, cam_data, frame_start,
                                frame_done, underflow, busy}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_pclk", pclk, 0);
        check("idle_busy", busy, 0);
        load_frame(-1);
        load_frame(1);
        load_frame(-1);
        enable = 1'b1;
        @(negedge clk);
        check("busy_after_enable", busy, 1);
        wait_for("start1", 0, 100);
        check("vsync_at_start", vsync, 1);
        wait_for("done1", 1, 400);
        check("no_underflow_f1", underflow, 0);
        wait_for("start2", 0, 10);
        wait_for("f2_href_hi", 2, 200);
        wait_for("f2_href_lo", 3, 100);
        check("underflow_set", underflow, 1);
        wait_for("f2_href_hi2", 2, 100);
        wait_for("f2_href_lo2", 3, 100);
        check("underflow_sticky", underflow, 1);
        wait_for("start3", 0, 200);
        check("underflow_cleared", underflow, 0);
        wait_for("f3_href_hi", 2, 200);
        wait_for("f3_href_lo", 3, 100);
        wait_for("f3_href_hi2", 2, 100);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_for("done3", 1, 400);
        check("no_restart_pulse", frame_start, 0);
        repeat (4) @(negedge clk);
        check("stop_pclk", pclk, 0);
        check("stop_busy", busy, 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            n += int'(frame_start);
        end
        check("stays_idle", n, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        check("stim_consumed", stim_q.size(), 0);
        load_frame(-1);
        enable = 1'b1;
        wait_for("start4", 0, 100);
        wait_for("f4_href_hi", 2, 200);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {pix_ready, pclk, vsync, href, cam_data, frame_start,
                                          frame_done, underflow, busy}, 0);
        in_frame = 1'b0;
        stim_q.delete();
        exp_q.delete();
        load_frame(-1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_for("start5", 0, 100);
        check("restart_vsync", {vsync, href, busy}, 3'b101);
        enable = 1'b0;
        wait_for("done5", 1, 400);
        repeat (4) @(negedge clk);
        check("final_idle", {pclk, busy}, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
